// File: rtl/instruction_loader.sv
// Purpose: packs a big-endian byte stream into 32-bit instruction words and writes them to imem.
// Latency: mem_we/mem_addr/mem_wdata are registered, one cycle after the 4th byte of each word.
// Backpressure: in_ready is high only while loading (LOAD/CHECK); no internal buffering.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, word_count     load request (sampled in IDLE/DONE) and number of words to load
//   in_valid/in_ready/in_data   byte stream handshake
//   mem_we/mem_addr/mem_wdata   instruction memory write port (byte address, word aligned)
//   busy, done, error     CPU stall, load completed, request rejected / checksum failed
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing big-endian XOR
// checksum word after the image; the loader then reports error on mismatch.
module instruction_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_WC  = MAX_WORDS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   WC_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH:0]   wc_last;   // word_count-1, kept one bit wider to avoid truncation
  logic [1:0]            byte_cnt;
  logic [23:0]           word_sr;   // first three bytes of the word in progress
  logic [31:0]           next_word;
  logic                  xfer;
  logic                  last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           xor_acc;
`endif

  // in_ready is a registered copy of "state is LOAD or CHECK", so it is safe to
  // use directly for the handshake.
  assign xfer      = in_valid && in_ready;
  assign next_word = {word_sr, in_data};
  assign last_byte = (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wc_last   <= '0;
      byte_cnt  <= '0;
      word_sr   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_acc   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (word_count > MAX_WC) begin
              // Rejected request: flag it but stay where we are.
              error <= 1'b1;
              done  <= 1'b0;
            end else if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b0;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              error    <= 1'b0;
              idx      <= '0;
              byte_cnt <= '0;
              wc_last  <= word_count - WC_ONE;
`ifdef LOADER_CHECKSUM_EN
              xor_acc  <= '0;
`endif
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            word_sr  <= next_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_wdata <= next_word;
              mem_addr  <= {{(30-ADDR_WIDTH){1'b0}}, idx, 2'b00};
`ifdef LOADER_CHECKSUM_EN
              xor_acc   <= xor_acc ^ next_word;
`endif
              if ({1'b0, idx} == wc_last) begin
`ifdef LOADER_CHECKSUM_EN
                // in_ready/busy stay high to collect the checksum word.
                state <= CHECK;
`else
                state    <= DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
                busy     <= 1'b0;
`endif
              end else begin
                idx <= idx + IDX_ONE;
              end
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            word_sr  <= next_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              if (next_word == xor_acc) begin
                done <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  // Write log, filled only by the monitor below.
  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          base;

  logic [7:0] img [0:7] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};

`ifdef LOADER_CHECKSUM_EN
  localparam logic DONE_AT_LAST = 1'b0;
`else
  localparam logic DONE_AT_LAST = 1'b1;
`endif

  instruction_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one byte; returns on the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [10:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checksum word (if the feature is built in); no-op otherwise.
  task automatic send_csum(input logic [31:0] w);
`ifdef LOADER_CHECKSUM_EN
    check("csum_pre_done", 32'(done), 32'd0);
    send_word(w, 0);
`else
    if (w == 32'hFFFF_FFFF) $display("unexpected checksum word");
`endif
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", mem_addr,      32'd0);
    check("rst_mem_wdata", mem_wdata,    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- basic load, back-to-back ----------------
    base = wr_cnt;
    do_start(11'd2);
    check("basic_in_ready", 32'(in_ready), 32'd1);
    check("basic_busy",     32'(busy),     32'd1);
    for (int i = 0; i < 7; i++) send_byte(img[i]);
    // Start coincident with the final transfer must be ignored.
    start = 1'b1;
    word_count = 11'd1;
    send_byte(img[7]);
    start = 1'b0;
    check("basic_last_we",   32'(mem_we), 32'd1);
    check("basic_last_addr", mem_addr,    32'd4);
    check("basic_last_data", mem_wdata,   32'h01095020);
    check("basic_done_at_we", 32'(done),  32'(DONE_AT_LAST));
    check("basic_w0_addr", wr_addr[base], 32'd0);
    check("basic_w0_data", wr_data[base], 32'h20080005);
`ifndef LOADER_CHECKSUM_EN
    check("basic_busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    check("basic_start_ignored", 32'(in_ready), 32'd0);
    check("basic_we_one_cycle", 32'(mem_we), 32'd0);
`endif
    send_csum(32'h21015025);
    @(negedge clk);
    check("basic_done", 32'(done), 32'd1);
    check("basic_error", 32'(error), 32'd0);
    check("basic_nwrites", 32'(wr_cnt - base), 32'd2);

    // ---------------- restart + stalled stream + start while busy ----------------
    base = wr_cnt;
    do_start(11'd2);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      if (i == 2) begin
        start = 1'b1;
        word_count = 11'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
      end else if (i != 7) begin
        repeat (3) @(negedge clk);
      end
    end
    check("stall_last_addr", mem_addr, 32'd4);
    check("stall_last_data", mem_wdata, 32'h01095020);
    send_csum(32'h21015025);
    repeat (3) @(negedge clk);
    check("stall_nwrites", 32'(wr_cnt - base), 32'd2);
    check("stall_w0_addr", wr_addr[base], 32'd0);
    check("stall_w0_data", wr_data[base], 32'h20080005);
    check("stall_done", 32'(done), 32'd1);

    // ---------------- word_count = 0 ----------------
    base = wr_cnt;
    do_start(11'd0);
    check("wc0_done", 32'(done), 32'd1);
    check("wc0_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("wc0_nwrites", 32'(wr_cnt - base), 32'd0);

    // ---------------- word_count = 1025 ----------------
    do_start(11'd1025);
    check("wc1025_error", 32'(error), 32'd1);
    check("wc1025_done", 32'(done), 32'd0);
    check("wc1025_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("wc1025_in_ready_hold", 32'(in_ready), 32'd0);
    check("wc1025_nwrites", 32'(wr_cnt - base), 32'd0);

    // ---------------- reset mid-word ----------------
    base = wr_cnt;
    do_start(11'd2);
    check("mid_error_clr", 32'(error), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_nwrites", 32'(wr_cnt - base), 32'd1);
    base = wr_cnt;
    do_start(11'd1);
    send_word(32'hDEADBEEF, 0);
    check("mid_reload_we", 32'(mem_we), 32'd1);
    check("mid_reload_addr", mem_addr, 32'd0);
    check("mid_reload_data", mem_wdata, 32'hDEADBEEF);
    send_csum(32'hDEADBEEF);
    @(negedge clk);
    check("mid_reload_done", 32'(done), 32'd1);
    check("mid_reload_nwrites", 32'(wr_cnt - base), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // ---------------- checksum mismatch ----------------
    base = wr_cnt;
    do_start(11'd2);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    send_word(32'h00000000, 0);
    @(negedge clk);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_nwrites", 32'(wr_cnt - base), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
